pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, writeback-driven redirects with a
// one-entry pending slot for stalled fetch, and trap capture (trap/epc/trap_cause are registered).
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = '0,
    parameter int unsigned     IALIGN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            wb_valid,
    input  logic [1:0]      jmp_op,
    input  logic            cmp,
    input  logic [XLEN-1:0] target,
    input  logic            fault,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [XLEN-1:0] epc
);

    typedef enum logic [1:0] {
        OP_SEQ = 2'd0,
        OP_JMP = 2'd1,
        OP_BR  = 2'd2,
        OP_ILL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_FAULT    = 2'd1,
        CAUSE_ILLEGAL  = 2'd2,
        CAUSE_MISALIGN = 2'd3
    } cause_e;

    logic            pend_vld;
    logic [XLEN-1:0] pend_addr;

    logic            taken;
    logic            misaligned;
    cause_e          cause;
    logic            trap_event;
    logic            redirect;
    logic [XLEN-1:0] redirect_addr;
    logic            fetch_go;
    logic [XLEN-1:0] next_pc;

    // Redirect decode; cause priority is fault > illegal op > misaligned target.
    always_comb begin
        taken         = 1'b0;
        misaligned    = 1'b0;
        cause         = CAUSE_NONE;
        trap_event    = 1'b0;
        redirect      = 1'b0;
        redirect_addr = target;
        fetch_go      = 1'b0;
        next_pc       = pc;

        if (wb_valid) begin
            taken      = (jmp_op == OP_JMP) || ((jmp_op == OP_BR) && cmp);
            misaligned = (IALIGN == 16) ? target[0] : (target[1:0] != 2'b00);
            if (fault) begin
                cause = CAUSE_FAULT;
            end else if (jmp_op == OP_ILL) begin
                cause = CAUSE_ILLEGAL;
            end else if (taken && misaligned) begin
                cause = CAUSE_MISALIGN;
            end
        end

        trap_event    = (cause != CAUSE_NONE);
        redirect      = trap_event || taken;
        redirect_addr = trap_event ? TRAP_VEC : target;

        // The pc is frozen during the single post-reset cycle with pc_valid low.
        fetch_go = fetch_ready && pc_valid;
        if (fetch_go) begin
            if (redirect) begin
                next_pc = redirect_addr;
            end else if (pend_vld) begin
                next_pc = pend_addr;
            end else begin
                next_pc = pc + XLEN'(4);
            end
        end
    end

    // State registers: pc, pending redirect slot, trap capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_VEC;
            pc_valid   <= 1'b0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
            epc        <= '0;
        end else begin
            pc_valid <= 1'b1;
            pc       <= next_pc;
            trap     <= trap_event;
            if (trap_event) begin
                epc        <= pc;
                trap_cause <= cause;
            end
            if (fetch_go) begin
                pend_vld <= 1'b0;
            end else if (redirect) begin
                pend_vld  <= 1'b1;
                pend_addr <= redirect_addr;
            end
        end
    end

endmodule
